// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite transfer codes and SRAM slave geometry defaults
package ahb_pkg;
    localparam int ADDR_W_DEF   = 15;
    localparam int BANK_LSB_DEF = 17;
    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] SZ_BYTE   = 3'd0;
    localparam logic [2:0] SZ_HALF   = 3'd1;
    localparam logic [2:0] SZ_WORD   = 3'd2;
endpackage

// File: rtl/ahb_lane_mask.sv
// ahb_lane_mask: little-endian byte-lane mask from transfer size and low address bits
module ahb_lane_mask
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);
    assign mask = hsize == SZ_BYTE ? 4'(4'b0001 << addr_lo)
                : hsize == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011)
                : 4'b1111;
endmodule

// File: rtl/ahb_sram.sv
// ahb_sram: AHB-Lite slave driving four banks of synchronous single-port SRAM
module ahb_sram
    import ahb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BANK_LSB = BANK_LSB_DEF
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic              HREADY,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    input  logic [31:0]       SRAMRDATA,
    output logic [3:0]        SRAMWEN,
    output logic [31:0]       SRAMWDATA,
    output logic              SRAMCS0,
    output logic              SRAMCS1,
    output logic              SRAMCS2,
    output logic              SRAMCS3,
    output logic [ADDR_W-1:0] SRAMADDR
);
    logic              accept, acc_wr, acc_rd;
    logic [3:0]        lane_mask;
    logic [ADDR_W-1:0] haddr_word, wr_addr, rd_addr;
    logic [1:0]        haddr_bank, wr_bank, rd_bank, bank;
    logic [3:0]        wr_mask;
    logic              wr_pend, rd_pend, cs_en;
    logic              unused_ok;

    assign accept     = HSEL & HTRANS[1] & HREADY;
    assign acc_wr     = accept & HWRITE;
    assign acc_rd     = accept & ~HWRITE;
    assign haddr_word = HADDR[ADDR_W+1:2];
    assign haddr_bank = HADDR[BANK_LSB+1:BANK_LSB];
    assign unused_ok  = ^{HADDR[31:BANK_LSB+2], HTRANS[0]};

    ahb_lane_mask u_lane_mask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (lane_mask)
    );

    // Pending-write and collided-read bookkeeping; a read that lands on a write data phase is replayed next cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend <= 1'b0;
            rd_pend <= 1'b0;
            wr_addr <= '0;
            wr_bank <= '0;
            wr_mask <= '0;
            rd_addr <= '0;
            rd_bank <= '0;
        end else begin
            wr_pend <= acc_wr;
            rd_pend <= acc_rd & wr_pend;
            if (acc_wr) begin
                wr_addr <= haddr_word;
                wr_bank <= haddr_bank;
                wr_mask <= lane_mask;
            end
            if (acc_rd & wr_pend) begin
                rd_addr <= haddr_word;
                rd_bank <= haddr_bank;
            end
        end
    end

    // SRAM port mux: write data phase wins, then replayed read, then a fresh read
    always_comb begin
        cs_en    = 1'b0;
        bank     = haddr_bank;
        SRAMADDR = haddr_word;
        SRAMWEN  = 4'b0000;
        if (wr_pend) begin
            cs_en    = 1'b1;
            bank     = wr_bank;
            SRAMADDR = wr_addr;
            SRAMWEN  = wr_mask;
        end else if (rd_pend) begin
            cs_en    = 1'b1;
            bank     = rd_bank;
            SRAMADDR = rd_addr;
        end else if (acc_rd) begin
            cs_en    = 1'b1;
        end
    end

    assign {SRAMCS3, SRAMCS2, SRAMCS1, SRAMCS0} = cs_en ? 4'(4'b0001 << bank) : 4'b0000;
    assign SRAMWDATA = HWDATA;
    assign HRDATA    = SRAMRDATA;
    assign HREADYOUT = ~rd_pend;
endmodule

// File: tb/tb_ahb_sram.sv
// tb_ahb_sram: directed-vector bench for ahb_sram with a four-bank SRAM model
module tb_ahb_sram;
    import ahb_pkg::*;

    logic        HCLK, HRESETn, HSEL, HWRITE, HREADYOUT;
    logic [31:0] HADDR, HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  SRAMWEN;
    logic        SRAMCS0, SRAMCS1, SRAMCS2, SRAMCS3;
    logic [14:0] SRAMADDR;
    logic [3:0]  cs;
    logic [31:0] mem [4][32768];
    logic        pre_en;
    logic [1:0]  pre_b;
    logic [14:0] pre_a;
    logic [31:0] pre_d;
    int          checks = 0, errors = 0, waits = 0;

    assign cs = {SRAMCS3, SRAMCS2, SRAMCS1, SRAMCS0};

    ahb_sram dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HREADY    (HREADYOUT),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMCS1   (SRAMCS1),
        .SRAMCS2   (SRAMCS2),
        .SRAMCS3   (SRAMCS3),
        .SRAMADDR  (SRAMADDR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Synchronous SRAM model: byte writes, registered read data, plus a preload port
    always @(posedge HCLK) begin
        if (pre_en) mem[pre_b][pre_a] <= pre_d;
        for (int b = 0; b < 4; b++) begin
            if (cs[b]) begin
                for (int k = 0; k < 4; k++)
                    if (SRAMWEN[k]) mem[b][SRAMADDR][8*k+:8] <= SRAMWDATA[8*k+:8];
                if (SRAMWEN == 4'b0000) SRAMRDATA <= mem[b][SRAMADDR];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [1:0] b, input logic [14:0] a, input logic [31:0] d);
        @(posedge HCLK);
        #1;
        pre_en = 1'b1; pre_b = b; pre_a = a; pre_d = d;
        @(posedge HCLK);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size; HWDATA = wdata;
        @(negedge HCLK);
    endtask

    logic [1:0]  b_tr [10] = '{HT_NONSEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_NONSEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_IDLE};
    logic        b_wr [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] b_ad [10] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h100, 32'h104, 32'h104, 32'h108, 32'h10C, 32'h0};
    logic [31:0] b_wd [10] = '{32'h0, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        b_rdy [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] b_rd [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
    logic        e_sel [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  e_tr [5] = '{HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ, HT_IDLE};
    logic [31:0] e_ad [5] = '{32'h1234, 32'h5678, 32'h9ABC, 32'h20004, 32'h60008};

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = HT_IDLE; HWRITE = 1'b0;
        HADDR = '0; HSIZE = SZ_WORD; HWDATA = '0;
        pre_en = 1'b0; pre_b = '0; pre_a = '0; pre_d = '0;
        #1;
        check("rst_ready", 32'(HREADYOUT), 32'h1);
        check("rst_cs", 32'(cs), 32'h0);
        check("rst_wen", 32'(SRAMWEN), 32'h0);
        preload(2'd0, 15'd8, 32'h12345678);
        preload(2'd3, 15'd1, 32'h33330001);
        preload(2'd0, 15'h50, 32'h5555AAAA);
        @(negedge HCLK);
        HRESETn = 1'b1;

        drive(1'b1, HT_NONSEQ, 1'b1, 32'h10, SZ_WORD, 32'h0);
        check("a_addr_cs", 32'(cs), 32'h0);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'hDEADBEEF);
        check("a_wr_cs", 32'(cs), 32'h1);
        check("a_wr_addr", 32'(SRAMADDR), 32'h4);
        check("a_wr_wen", 32'(SRAMWEN), 32'hF);
        check("a_wr_data", SRAMWDATA, 32'hDEADBEEF);
        drive(1'b1, HT_NONSEQ, 1'b0, 32'h10, SZ_WORD, 32'h0);
        check("a_rd_cs", 32'(cs), 32'h1);
        check("a_rd_wen", 32'(SRAMWEN), 32'h0);
        check("a_rd_ready", 32'(HREADYOUT), 32'h1);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'h0);
        check("a_rd_ready2", 32'(HREADYOUT), 32'h1);
        check("a_rdata", HRDATA, 32'hDEADBEEF);

        drive(1'b1, HT_NONSEQ, 1'b1, 32'h21, SZ_BYTE, 32'h0);
        drive(1'b1, HT_NONSEQ, 1'b1, 32'h22, SZ_HALF, 32'h00001100);
        check("b_wen_byte", 32'(SRAMWEN), 32'h2);
        check("b_addr", 32'(SRAMADDR), 32'h8);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'hAABB0000);
        check("b_wen_half", 32'(SRAMWEN), 32'hC);
        drive(1'b1, HT_NONSEQ, 1'b0, 32'h20, SZ_WORD, 32'h0);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'h0);
        check("b_rdata", HRDATA, 32'hAABB1178);

        drive(1'b1, HT_NONSEQ, 1'b1, 32'h0002_0000, SZ_WORD, 32'h0);
        drive(1'b1, HT_NONSEQ, 1'b0, 32'h0006_0004, SZ_WORD, 32'hCAFEF00D);
        check("c_wr_cs", 32'(cs), 32'h2);
        check("c_wr_wen", 32'(SRAMWEN), 32'hF);
        check("c_wr_ready", 32'(HREADYOUT), 32'h1);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'h0);
        check("c_wait", 32'(HREADYOUT), 32'h0);
        check("c_rd_cs", 32'(cs), 32'h8);
        check("c_rd_addr", 32'(SRAMADDR), 32'h1);
        check("c_rd_wen", 32'(SRAMWEN), 32'h0);
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'h0);
        check("c_ready", 32'(HREADYOUT), 32'h1);
        check("c_rdata", HRDATA, 32'h33330001);
        check("c_mem", mem[1][0], 32'hCAFEF00D);

        for (int i = 0; i < 10; i++) begin
            drive(1'b1, b_tr[i], b_wr[i], b_ad[i], SZ_WORD, b_wd[i]);
            if (!HREADYOUT) waits++;
            check($sformatf("d_ready%0d", i), 32'(HREADYOUT), 32'(b_rdy[i]));
            if (i == 4) check("d_last_wr", {SRAMWEN, 13'h0, SRAMADDR}, {4'hF, 13'h0, 15'h43});
            if (i >= 6) check($sformatf("d_rdata%0d", i), HRDATA, b_rd[i]);
        end
        check("d_waits", 32'(waits), 32'h1);

        for (int i = 0; i < 5; i++) begin
            drive(e_sel[i], e_tr[i], 1'(i), e_ad[i], SZ_WORD, 32'h0);
            check($sformatf("e_idle%0d", i), {23'h0, cs, SRAMWEN, HREADYOUT}, 32'h1);
            check($sformatf("e_addr%0d", i), 32'(SRAMADDR), 32'(e_ad[i][16:2]));
        end

        drive(1'b1, HT_NONSEQ, 1'b1, 32'h140, SZ_WORD, 32'h0);
        @(posedge HCLK);
        #1;
        HSEL = 1'b0; HTRANS = HT_IDLE; HWDATA = 32'hFFFFFFFF; HRESETn = 1'b0;
        #1;
        check("f_cs", 32'(cs), 32'h0);
        check("f_wen", 32'(SRAMWEN), 32'h0);
        check("f_ready", 32'(HREADYOUT), 32'h1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive(1'b0, HT_IDLE, 1'b0, 32'h0, SZ_WORD, 32'hFFFFFFFF);
        check("f_dropped", {28'h0, cs}, 32'h0);
        @(posedge HCLK);
        #1;
        check("f_mem", mem[0][15'h50], 32'h5555AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
